// File: rtl/downcounter_timer_ctrl_pkg.sv
// downcounter_timer_ctrl_pkg: shared state encoding and mode constants for the timer controller
package downcounter_timer_ctrl_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD = 1'b1;
endpackage

// File: rtl/downcounter_load.sv
// downcounter_load: loadable down counter, ld over en; ports clk, rst (async low), ld, en, din -> q
module downcounter_load
  import downcounter_timer_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= '0;
    else if (ld) q <= din;
    else if (en) q <= q - 1'b1;
endmodule

// File: rtl/downcounter_timer_ctrl.sv
// downcounter_timer_ctrl: prescaled one-shot/auto-reload timer; in start/stop/hold/mode/period/prescale, out count/busy/tick/done
module downcounter_timer_ctrl
  import downcounter_timer_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic             mode,
  input  logic [WIDTH-1:0] period,
  input  logic [PRE_W-1:0] prescale,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tick,
  output logic             done
);
  logic [1:0] state;
  logic [WIDTH-1:0] period_l;
  logic [PRE_W-1:0] pre_l, pre_cnt;
  logic mode_l, active, step, expire, ld, en;
  logic [WIDTH-1:0] din;
  always_comb begin
    active = state != IDLE && !stop && !start;
    step = active && !hold && pre_cnt == '0;
    expire = step && count == '0;
    ld = (start && !stop) || (expire && mode_l == MODE_RELOAD);
    din = start ? period : period_l;
    en = step && count != '0;
    busy = state != IDLE;
  end
  downcounter_load #(.WIDTH(WIDTH)) u_cnt (
    .clk(clk),
    .rst(rst),
    .ld(ld),
    .en(en),
    .din(din),
    .q(count)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      period_l <= '0;
      pre_l <= '0;
      pre_cnt <= '0;
      mode_l <= MODE_ONESHOT;
      tick <= 1'b0;
      done <= 1'b0;
    end else begin
      tick <= expire;
      if (stop) state <= IDLE;
      else if (start) begin
        state <= RUN;
        period_l <= period;
        pre_l <= prescale;
        mode_l <= mode;
        pre_cnt <= prescale;
        done <= 1'b0;
      end else if (state != IDLE) begin
        state <= hold ? HOLD : (expire && mode_l == MODE_ONESHOT) ? IDLE : RUN;
        if (!hold) pre_cnt <= pre_cnt != '0 ? pre_cnt - 1'b1 : pre_l;
        if (expire && mode_l == MODE_ONESHOT) done <= 1'b1;
      end
    end
endmodule

// File: tb/tb_downcounter_timer_ctrl.sv
// tb_downcounter_timer_ctrl: directed bench with a tick-time scoreboard for downcounter_timer_ctrl
module tb_downcounter_timer_ctrl;
  import downcounter_timer_ctrl_pkg::*;
  localparam int WIDTH = 4;
  localparam int PRE_W = 4;
  logic clk = 0, rst = 0, start = 0, stop = 0, hold = 0, mode = 0;
  logic [WIDTH-1:0] period = '0;
  logic [PRE_W-1:0] prescale = '0;
  logic [WIDTH-1:0] count;
  logic busy, tick, done;
  int n_chk = 0, n_fail = 0, cyc = 0;
  int exp_q[$];
  downcounter_timer_ctrl #(.WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .stop(stop),
    .hold(hold),
    .mode(mode),
    .period(period),
    .prescale(prescale),
    .count(count),
    .busy(busy),
    .tick(tick),
    .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tk();
    @(posedge clk);
    #1;
    cyc++;
    if (exp_q.size() > 0 && exp_q[0] == cyc) begin
      void'(exp_q.pop_front());
      chk($sformatf("tick_hi@%0d", cyc), 32'(tick), 1);
    end else chk($sformatf("tick_lo@%0d", cyc), 32'(tick), 0);
  endtask
  task automatic go(input logic [WIDTH-1:0] p, input logic [PRE_W-1:0] s, input logic m);
    period = p;
    prescale = s;
    mode = m;
    start = 1;
    tk();
    start = 0;
  endtask
  initial begin
    #3;
    chk("rst_count", 32'(count), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_done", 32'(done), 0);
    @(negedge clk);
    rst = 1;
    tk();
    tk();
    chk("idle_count", 32'(count), 0);
    chk("idle_busy", 32'(busy), 0);
    exp_q.push_back(4);
    cyc = -1;
    go(3, 0, MODE_ONESHOT);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tk();
      chk($sformatf("os_count@%0d", i), 32'(count), 32'(3 - i));
      chk($sformatf("os_busy@%0d", i), 32'(busy), 1);
    end
    tk();
    chk("os_done", 32'(done), 1);
    chk("os_busy_end", 32'(busy), 0);
    chk("os_count_end", 32'(count), 0);
    tk();
    tk();
    chk("os_idle_count", 32'(count), 0);
    exp_q.push_back(6);
    exp_q.push_back(12);
    exp_q.push_back(18);
    cyc = -1;
    go(2, 1, MODE_RELOAD);
    chk("ar_done_clr", 32'(done), 0);
    repeat (19) begin
      tk();
      if (cyc % 6 == 0) chk($sformatf("ar_reload@%0d", cyc), 32'(count), 2);
    end
    chk("ar_done", 32'(done), 0);
    chk("ar_busy", 32'(busy), 1);
    stop = 1;
    tk();
    stop = 0;
    chk("ar_stop_busy", 32'(busy), 0);
    exp_q.push_back(7);
    cyc = -1;
    go(3, 0, MODE_ONESHOT);
    tk();
    tk();
    hold = 1;
    repeat (3) begin
      tk();
      chk($sformatf("hold_count@%0d", cyc), 32'(count), 1);
      chk($sformatf("hold_busy@%0d", cyc), 32'(busy), 1);
    end
    hold = 0;
    tk();
    chk("hold_resume", 32'(count), 0);
    tk();
    chk("hold_done", 32'(done), 1);
    cyc = -1;
    go(5, 0, MODE_ONESHOT);
    tk();
    tk();
    stop = 1;
    tk();
    stop = 0;
    chk("stop_busy", 32'(busy), 0);
    chk("stop_count", 32'(count), 3);
    chk("stop_done", 32'(done), 0);
    repeat (8) tk();
    chk("stop_frozen", 32'(count), 3);
    exp_q.push_back(2);
    cyc = -1;
    go(1, 0, MODE_ONESHOT);
    tk();
    tk();
    chk("rs_done", 32'(done), 1);
    cyc = -1;
    go(4, 0, MODE_RELOAD);
    tk();
    exp_q.push_back(4);
    exp_q.push_back(6);
    period = 1;
    start = 1;
    tk();
    start = 0;
    chk("rb_count", 32'(count), 1);
    repeat (5) tk();
    stop = 1;
    tk();
    stop = 0;
    cyc = -1;
    go(1, 0, MODE_RELOAD);
    tk();
    exp_q.push_back(4);
    start = 1;
    tk();
    start = 0;
    chk("rx_count", 32'(count), 1);
    tk();
    tk();
    stop = 1;
    tk();
    stop = 0;
    exp_q.push_back(3);
    cyc = -1;
    go(0, 2, MODE_ONESHOT);
    repeat (4) tk();
    chk("pre_done", 32'(done), 1);
    chk("pre_busy", 32'(busy), 0);
    exp_q.push_back(5);
    hold = 1;
    cyc = -1;
    go(2, 0, MODE_ONESHOT);
    chk("sh_busy", 32'(busy), 1);
    chk("sh_count", 32'(count), 2);
    tk();
    tk();
    chk("sh_frozen", 32'(count), 2);
    hold = 0;
    repeat (4) tk();
    chk("sh_done", 32'(done), 1);
    stop = 1;
    tk();
    stop = 0;
    chk("idle_stop_done", 32'(done), 1);
    chk("idle_stop_busy", 32'(busy), 0);
    exp_q.push_back(1);
    cyc = -1;
    go(0, 0, MODE_RELOAD);
    tk();
    #3;
    rst = 0;
    #1;
    chk("mid_rst_tick", 32'(tick), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_done", 32'(done), 0);
    @(negedge clk);
    rst = 1;
    repeat (3) tk();
    chk("q_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/downcounter_timer_ctrl.md
Name: downcounter_timer_ctrl

Overview:
Programmable timer controller built around a loadable synchronous down counter. It latches a period and a prescale value on start, then sequences the counter's load and enable. It raises a one-cycle tick when the count expires, in either one-shot or auto-reload mode. It sits between a control register interface (start/stop/hold/mode) and any logic that needs periodic or delayed events.

Parameters:
WIDTH, 4, width of the period and count.
PRE_W, 4, width of the prescale value; the count steps once every prescale+1 cycles.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-low reset.
start  input  1  level-sampled; latches period, prescale and mode, then (re)starts counting.
stop  input  1  aborts the run and returns to IDLE with no tick.
hold  input  1  freezes the counter and prescaler while high in RUN.
mode  input  1  0 = one-shot, 1 = auto-reload; sampled with start.
period  input  WIDTH  initial count value.
prescale  input  PRE_W  prescaler reload value.
count  output  WIDTH  current counter value.
busy  output  1  high in RUN or HOLD.
tick  output  1  registered one-cycle pulse on expiry.
done  output  1  sticky; set on one-shot expiry, cleared by start or reset.

Behaviour:
- Reset (rst low, async): state=IDLE; count=0, pre_cnt=0, tick=0, done=0, busy=0. Latched period, prescale and mode all go to 0.
- States: IDLE, RUN, HOLD. busy is a decode of state (RUN or HOLD).
- Command priority, evaluated every edge: stop > start > hold.
- IDLE + start: at that edge latch period_l=period, pre_l=prescale and mode_l=mode. Also count<=period, pre_cnt<=prescale, done<=0, state<=RUN.
- IDLE without start: all registers hold; count keeps its last value.
- RUN: a step occurs on each edge where pre_cnt==0 and hold==0.
  - When pre_cnt!=0, pre_cnt decrements.
  - Step with count!=0: count<=count-1, pre_cnt<=pre_l.
  - Step with count==0: tick<=1.
    - mode_l=1: count<=period_l, pre_cnt<=pre_l; stay in RUN.
    - mode_l=0: state<=IDLE, done<=1; count stays 0.
- Expiry timing: tick is high in the cycle after edge N=(P+1)*(S+1), counting the start edge as edge 0.
  - In auto-reload, tick repeats every (P+1)*(S+1) cycles.
  - P=0 is legal: one step to expiry.
  - tick is low on every cycle that is not an expiry.
- RUN + hold=1 (no stop/start): state<=HOLD. count and pre_cnt are frozen on that edge and stay frozen while hold stays high.
- HOLD + hold=0: state<=RUN. Counting resumes on the next edge, so total latency grows by exactly the number of edges spent with hold high.
- stop in RUN or HOLD: state<=IDLE at that edge. No tick; done unchanged; count frozen at its current value.
- stop in IDLE: no effect.
- start while busy (stop low): restart. Relatch all inputs, reload count and pre_cnt, done<=0, state<=RUN, no tick.
  - If the same edge would have been an expiry step, the restart wins and no tick is produced.
- start and hold both high in IDLE: start takes effect and state goes to RUN. hold is then honoured from the next edge onward.
- Reset asserted mid-run: immediate return to reset values; any pending tick is lost.
- Wrap-around: count never decrements below 0. The zero step reloads (auto-reload) or stops (one-shot).
- All outputs are registered or state-decoded; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package: the state encoding (IDLE=2'd0, RUN=2'd1, HOLD=2'd2) and the mode constants (MODE_ONESHOT=0, MODE_RELOAD=1).
- One natural sub-module: downcounter_load, with ports clk, rst, ld, en, din[WIDTH-1:0] and q.
  - A loadable synchronous down counter with ld priority over en.
  - The FSM drives ld on start or reload, and en on non-zero steps.
- The prescaler and the FSM stay in the top module.

Test Plan:
- Reset: drive rst low mid-cycle → count=0, tick=0, done=0, busy=0 immediately, without waiting for a clock edge.
- One-shot, P=3, S=0, start pulse at edge 0 → count 3,2,1,0 at edges 0..3; tick high only after edge 4; then done=1, busy=0, count=0.
- Auto-reload, P=2, S=1 → ticks after edges 6, 12 and 18; count reloads to 2 each time; done stays 0.
- Hold: one-shot P=3, S=0, hold high for 3 edges starting at edge 2 → tick after edge 7; count frozen at 1 during HOLD.
- Stop, then restart: one-shot P=5, S=0, stop at edge 3 → no tick, busy=0, count=3. Then start with P=1 → tick 2 edges later.
- Restart while busy: auto-reload P=4, S=0, start reasserted with P=1 at edge 2 → tick 2 edges later, not at edge 5.
